ram_stream_reader: RTL and testbench
====================================

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 Parameter ADDR_W, default 10, RAM word-address width (depth 2**ADDR_W = 1024).
REQ-002 Parameter DATA_W, default 32, RAM word width.
REQ-003 Clocking: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 start  in  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-007 base_addr  in  ADDR_W  first word address, captured on an accepted start.
REQ-008 length  in  ADDR_W+1  word count 0..1024, captured on an accepted start.
REQ-009 busy  out  1  high from the cycle after an accepted start until the done cycle inclusive.
REQ-010 done  out  1  one-cycle pulse at burst completion.
REQ-011 ram_address  out  ADDR_W  read address, driven to the dual-port RAM wrapper port B.
REQ-012 ram_rden  out  1  read enable to port B; RAM returns data one cycle later.
REQ-013 ram_rdata  in  DATA_W  port-B read data, valid in the cycle after ram_rden.
REQ-014 out_data  out  DATA_W  stream word.
REQ-015 out_valid  out  1  out_data valid.
REQ-016 out_ready  in  1  consumer accepts when out_valid && out_ready at a rising edge.

Function
REQ-017 States: IDLE, READ, DRAIN; IDLE->READ on start with length!=0; IDLE->DRAIN on start with length==0.
REQ-018 READ issues reads at addresses base_addr, base_addr+1, ... modulo 2**ADDR_W (1023 wraps to 0).
REQ-019 READ->DRAIN in the cycle after the length-th read is issued.
REQ-020 DRAIN->IDLE when the FIFO is empty and no read is in flight; done=1 for that one cycle; busy falls the cycle after.
REQ-021 Zero length: done pulses the cycle after start; no ram_rden assertion.
REQ-022 start while busy is ignored; captured base_addr and length remain unchanged.
REQ-023 Internal 2-entry FIFO holds returned words; ram_rdata is written one cycle after its ram_rden.
REQ-024 ram_rden=1 in READ only when occupancy + in-flight - (pop this cycle) < 2, so the FIFO never overflows.
REQ-025 ram_rden is combinational from registered state and out_ready; ram_address is registered and advances only on an issued read.
REQ-026 When ram_rden=0, ram_address holds its last value.
REQ-027 out_valid = FIFO non-empty; out_data = FIFO head; head is stable while out_valid && !out_ready.
REQ-028 Simultaneous push and pop on a full or one-entry FIFO keeps occupancy unchanged, with no loss or duplication.
REQ-029 Latency: start at cycle 0 gives ram_rden in cycle 1 and out_valid in cycle 3; with out_ready held high, one word per cycle.
REQ-030 Words emerge in address order, exactly length words per burst.

Reset
REQ-031 On reset assertion, asynchronously: state=IDLE, ram_rden=0, ram_address=0, out_valid=0, out_data=0, busy=0, done=0, FIFO and in-flight flag cleared.
REQ-032 Reset mid-burst discards the in-flight read and FIFO contents; no word is emitted after reset.
REQ-033 After deassertion, the block is idle and accepts start on the first following edge.

Verification
REQ-034 RAM preloaded ram[i]=i; start base=5, length=4, out_ready=1 -> out_data 5,6,7,8 on consecutive cycles 3..6, done at cycle 7, ram_rden high in cycles 1..4.
REQ-035 Wrap: base=1022, length=4 -> addresses 1022,1023,0,1; data 1022,1023,0,1.
REQ-036 Backpressure: length=6, out_ready low cycles 4..8 -> out_valid held, out_data stable, ram_rden low once 2 words are buffered, all 6 words delivered in order, none lost.
REQ-037 length=0 -> done at cycle 1, busy only in cycle 1, ram_rden never asserted; length=1024 -> 1024 words, addresses wrap back to base_addr-1.
REQ-038 Second start while busy -> ignored, original burst completes unchanged; reset asserted mid-burst in cycle 3 -> all outputs 0 immediately, then a new start runs a clean burst.

Source files
------------

// File: rtl/ram_stream_reader_if.sv
// ram_stream_reader_if: bundles the burst-control, RAM port-B and output-stream
// signals of ram_stream_reader.
//   start/base_addr/length : burst request (driver -> reader)
//   busy/done              : burst status (reader -> driver)
//   ram_address/ram_rden   : port-B read request (reader -> RAM)
//   ram_rdata              : port-B read data, one cycle after ram_rden
//   out_data/out_valid     : stream word (reader -> consumer)
//   out_ready              : consumer accept
// slave = the reader, master = its environment.
interface ram_stream_reader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_rden;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  start, base_addr, length, ram_rdata, out_ready,
        output busy, done, ram_address, ram_rden, out_data, out_valid
    );

    modport master (
        output start, base_addr, length, ram_rdata, out_ready,
        input  busy, done, ram_address, ram_rden, out_data, out_valid
    );
endinterface

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: reads a burst of `length` words from a 1-cycle-latency RAM
// port starting at base_addr (wrapping modulo 2**ADDR_W) and streams them out
// through a 2-entry FIFO with valid/ready flow control.
//   clk_i : rising-edge clock
//   rst_i : asynchronous active-high reset
//   bus   : ram_stream_reader_if.slave (request, status, RAM port B, stream)
module ram_stream_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    ram_stream_reader_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t            state_q;
    logic [ADDR_W:0]   rem_q;       // reads still to issue
    logic [ADDR_W-1:0] addr_q;      // next read address
    logic              inflight_q;  // a read was issued last cycle
    logic [1:0]        cnt_q;       // FIFO occupancy 0..2
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [DATA_W-1:0] mem_q [2];

    logic       pop;
    logic       rden;
    logic       done;
    logic [2:0] occ;

    // A read may issue only if the word it returns is guaranteed a FIFO slot:
    // count words already buffered or on their way, minus the one leaving now.
    always_comb begin
        pop  = (cnt_q != 2'd0) && bus.out_ready;
        occ  = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
        rden = (state_q == READ) && (occ < 3'd2);
        done = (state_q == DRAIN) && (cnt_q == 2'd0) && !inflight_q;
    end

    assign bus.ram_rden    = rden;
    assign bus.ram_address = addr_q;
    assign bus.done        = done;
    assign bus.busy        = (state_q != IDLE);
    assign bus.out_valid   = (cnt_q != 2'd0);
    assign bus.out_data    = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            cnt_q      <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
        end else begin
            inflight_q <= rden;

            // Returned word lands in the FIFO the cycle after its read.
            if (inflight_q) begin
                mem_q[wr_ptr_q] <= bus.ram_rdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + 2'(inflight_q) - 2'(pop);

            if (rden) addr_q <= addr_q + 1'b1;

            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        addr_q  <= bus.base_addr;
                        rem_q   <= bus.length;
                        state_q <= (bus.length == '0) ? DRAIN : READ;
                    end
                end
                READ: begin
                    if (rden) begin
                        rem_q <= rem_q - 1'b1;
                        if (rem_q == {{ADDR_W{1'b0}}, 1'b1}) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (done) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_stream_reader.sv
module tb_ram_stream_reader;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ram_stream_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_stream_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int rmode = 0;           // 0: out_ready driven by main flow, 1: random
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] exp_data [$];
    logic [AW-1:0] exp_addr [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // RAM model: port-B sampled before the edge, data appears after it.
    initial begin
        logic          r_en;
        logic [AW-1:0] r_a;
        forever begin
            @(negedge clk);
            r_en = bus.ram_rden;
            r_a  = bus.ram_address;
            @(posedge clk);
            if (r_en) bus.ram_rdata <= mem[r_a];
        end
    end

    // Random consumer backpressure.
    initial forever begin
        @(posedge clk); #1;
        if (rmode == 1) bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    // Scoreboard monitor: address order, data order, stall stability, done pulses.
    initial begin
        logic          stall = 1'b0;
        logic [DW-1:0] stall_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (bus.ram_rden) begin
                    if (exp_addr.size() == 0) chk("extra_read", 1, 0);
                    else chk("ram_address", 64'(bus.ram_address), 64'(exp_addr.pop_front()));
                end
                if (stall) begin
                    chk("stall_valid", 64'(bus.out_valid), 1);
                    chk("stall_data", 64'(bus.out_data), 64'(stall_data));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_data.size() == 0) chk("extra_word", 1, 0);
                    else chk("out_data", 64'(bus.out_data), 64'(exp_data.pop_front()));
                end
                stall      = bus.out_valid && !bus.out_ready;
                stall_data = bus.out_data;
                if (bus.done) done_cnt++;
            end
        end
    end

    // Issue a start in the current cycle (cycle 0); returns in cycle 1.
    task automatic go(input int base, input int len, input bit expect_run);
        bus.start     = 1'b1;
        bus.base_addr = AW'(base);
        bus.length    = (AW+1)'(len);
        if (expect_run)
            for (int k = 0; k < len; k++) begin
                exp_addr.push_back(AW'((base + k) % DEPTH));
                exp_data.push_back(mem[(base + k) % DEPTH]);
            end
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) chk("burst_timeout", 1, 0);
        chk("words_left", 64'(exp_data.size()), 0);
        chk("reads_left", 64'(exp_addr.size()), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int d0;
        bus.start = 1'b0; bus.base_addr = '0; bus.length = '0;
        bus.out_ready = 1'b1; bus.ram_rdata = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);

        // Reset state
        #1 rst = 1'b1;
        #2;
        chk("rst_busy", 64'(bus.busy), 0);
        chk("rst_done", 64'(bus.done), 0);
        chk("rst_rden", 64'(bus.ram_rden), 0);
        chk("rst_valid", 64'(bus.out_valid), 0);
        chk("rst_addr", 64'(bus.ram_address), 0);
        chk("rst_data", 64'(bus.out_data), 0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;

        // Basic timing: base 5, length 4, ready high
        d0 = done_cnt;
        go(5, 4, 1);
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            @(negedge clk);
            chk($sformatf("t_rden%0d", k), 64'(bus.ram_rden), 64'(k >= 1 && k <= 4));
            chk($sformatf("t_valid%0d", k), 64'(bus.out_valid), 64'(k >= 3 && k <= 6));
            chk($sformatf("t_done%0d", k), 64'(bus.done), 64'(k == 7));
            chk($sformatf("t_busy%0d", k), 64'(bus.busy), 64'(k <= 7));
        end
        @(posedge clk); #1;
        chk("t_done_cnt", 64'(done_cnt - d0), 1);

        // Wrap around top of memory
        d0 = done_cnt;
        go(1022, 4, 1);
        wait_idle(50);
        chk("wrap_done_cnt", 64'(done_cnt - d0), 1);

        // Zero length
        d0 = done_cnt;
        go(77, 0, 1);
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            @(negedge clk);
            chk($sformatf("z_done%0d", k), 64'(bus.done), 64'(k == 1));
            chk($sformatf("z_busy%0d", k), 64'(bus.busy), 64'(k == 1));
            chk($sformatf("z_rden%0d", k), 64'(bus.ram_rden), 0);
        end
        @(posedge clk); #1;
        chk("z_done_cnt", 64'(done_cnt - d0), 1);

        // Backpressure: length 6, out_ready low in cycles 4..8
        go(300, 6, 1);
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            bus.out_ready = !(k >= 4 && k <= 8);
            @(negedge clk);
            if (k >= 4 && k <= 8) begin
                chk($sformatf("bp_rden%0d", k), 64'(bus.ram_rden), 0);
                chk($sformatf("bp_valid%0d", k), 64'(bus.out_valid), 1);
            end
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_idle(50);

        // Start while busy is ignored
        d0 = done_cnt;
        go(100, 6, 1);
        @(posedge clk); #1;
        go(200, 3, 0);
        wait_idle(60);
        repeat (3) @(posedge clk);
        #1;
        chk("ign_busy", 64'(bus.busy), 0);
        chk("ign_done_cnt", 64'(done_cnt - d0), 1);

        // Reset mid-burst in cycle 3
        go(40, 8, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("mr_rden", 64'(bus.ram_rden), 0);
        chk("mr_valid", 64'(bus.out_valid), 0);
        chk("mr_data", 64'(bus.out_data), 0);
        chk("mr_busy", 64'(bus.busy), 0);
        chk("mr_done", 64'(bus.done), 0);
        chk("mr_addr", 64'(bus.ram_address), 0);
        exp_data.delete();
        exp_addr.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        d0 = done_cnt;
        go(900, 5, 1);
        wait_idle(50);
        chk("mr_done_cnt", 64'(done_cnt - d0), 1);

        // Full-depth burst
        go(700, 1024, 1);
        wait_idle(1100);

        // Randomized bursts, random contents and backpressure
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        rmode = 1;
        for (int n = 0; n < 14; n++) begin
            int b, l;
            b  = $urandom_range(0, DEPTH - 1);
            l  = (n == 3) ? 0 : $urandom_range(1, 40);
            d0 = done_cnt;
            go(b, l, 1);
            wait_idle(l * 8 + 60);
            chk("rnd_done_cnt", 64'(done_cnt - d0), 1);
        end
        rmode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
